// File: rtl/bip_pkg.sv
// Shared BIP I definitions: ISA-fixed widths and data memory state encoding.
package bip_pkg;

  localparam int BIP_ADDR_W = 11;
  localparam int BIP_DATA_W = 16;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_IDLE  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/bip_data_memory_if.sv
// CPU data port bundle between the BIP I core (master) and its data memory (slave).
interface bip_data_memory_if
  import bip_pkg::*;
#(
  parameter int ADDR_W = BIP_ADDR_W,
  parameter int DATA_W = BIP_DATA_W
);

  logic              Rd;
  logic              Wr;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] In_Data;
  logic [DATA_W-1:0] Out_Data;
  logic              Busy;
  logic              AddrErr;

  modport master (
    output Rd,
    output Wr,
    output DataAddr,
    output In_Data,
    input  Out_Data,
    input  Busy,
    input  AddrErr
  );

  modport slave (
    input  Rd,
    input  Wr,
    input  DataAddr,
    input  In_Data,
    output Out_Data,
    output Busy,
    output AddrErr
  );

endinterface

// File: rtl/bip_ram_core.sv
// Word array with one negedge write port, one negedge registered read port
// (with synchronous clear) and an asynchronous debug read port.
module bip_ram_core #(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit one word per negedge when the controller enables the write port.
  always_ff @(negedge Clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read data; clear takes priority so reset and bad reads give zero.
  always_ff @(negedge Clock) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

  assign dbg_data = mem[dbg_idx];

endmodule

// File: rtl/bip_data_memory.sv
// BIP I data RAM: zero-fill sweep after reset, CPU read/write service on the
// negedge, sticky out-of-range flag and a combinational debug read port.
module bip_data_memory
  import bip_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = BIP_ADDR_W,
  parameter int DATA_W = BIP_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  bip_data_memory_if.slave  bus,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data
);

  // Index width into the physical array; range checks guard the upper bits.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH = 2^ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  mem_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              addr_err, addr_err_nxt;

  logic              req_in_range;
  logic              dbg_in_range;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              rd_clr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dbg_data;

  assign req_in_range = ({1'b0, bus.DataAddr} < DEPTH_X);
  assign dbg_in_range = ({1'b0, Dbg_Addr} < DEPTH_X);

  // Controller registers: state, sweep pointer and sticky error, reset synchronously.
  always_ff @(negedge Clock) begin
    if (Reset) begin
      state    <= MEM_CLEAR;
      clr_ptr  <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_ptr  <= clr_ptr_nxt;
      addr_err <= addr_err_nxt;
    end
  end

  // Next state and RAM port control; nothing touches the array while Reset is high.
  always_comb begin
    state_nxt    = state;
    clr_ptr_nxt  = clr_ptr;
    addr_err_nxt = addr_err;
    wr_en        = 1'b0;
    wr_idx       = bus.DataAddr[IDX_W-1:0];
    wr_data      = bus.In_Data;
    rd_en        = 1'b0;
    rd_clr       = Reset;
    if (!Reset) begin
      case (state)
        MEM_CLEAR: begin
          wr_en   = 1'b1;
          wr_idx  = clr_ptr[IDX_W-1:0];
          wr_data = '0;
          if (clr_ptr == LAST_PTR) begin
            state_nxt   = MEM_IDLE;
            clr_ptr_nxt = '0;
          end else begin
            clr_ptr_nxt = clr_ptr + 1'b1;
          end
        end
        MEM_IDLE: begin
          if (bus.Rd) begin
            if (req_in_range) begin
              rd_en = 1'b1;
            end else begin
              rd_clr       = 1'b1;
              addr_err_nxt = 1'b1;
            end
          end else if (bus.Wr) begin
            if (req_in_range) begin
              wr_en = 1'b1;
            end else begin
              addr_err_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = MEM_CLEAR;
        end
      endcase
    end
  end

  bip_ram_core #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_core (
    .Clock    (Clock),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_clr   (rd_clr),
    .rd_idx   (bus.DataAddr[IDX_W-1:0]),
    .rd_data  (rd_data),
    .dbg_idx  (Dbg_Addr[IDX_W-1:0]),
    .dbg_data (dbg_data)
  );

  assign bus.Out_Data = rd_data;
  assign bus.Busy     = (state == MEM_CLEAR);
  assign bus.AddrErr  = addr_err;
  assign Dbg_Data     = dbg_in_range ? dbg_data : '0;

endmodule
